sprite_line_loader: RTL
=======================

# sprite_line_loader

Per-scanline sprite scheduler that fills the sprite shift-stage chain during horizontal blank. On each `line_start` it clears the chain, scans the sprite attribute table, and for every sprite intersecting the line fetches one 32-bit pattern row. It then pushes attributes plus pattern into the chain with one `shift` pulse per hit, up to `SLOTS` sprites. It sits between the sprite attribute/pattern memories and the chain of shift stages feeding the pixel mixer.

## Interface
- `SPRITES`, 32: attribute entries scanned (power of 2, 2..64).
- `SLOTS`, 8: chain depth; max sprites loaded per line.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `line_start` in 1: one-cycle pulse, start of hblank.
- `line` in 8: scanline; sampled when `line_start` is accepted.
- `attr_rd` out 1: attribute read strobe.
- `attr_addr` out log2(SPRITES): attribute index.
- `attr_data` in 48: valid the cycle after `attr_rd`. Fields MSB→LSB: y[7:0], posX[8:0], sclX[3:0], swpX, bcolor1..4 [4:0] each, pat_idx[5:0].
- `pat_req` out 1: pattern fetch request; held until `pat_ack`.
- `pat_addr` out 10: {pat_idx, row[3:0]}; stable while `pat_req`.
- `pat_ack` in 1: `pat_data` valid this cycle.
- `pat_data` in 32: pattern row, 16 px × 2 bit.
- `clr` out 1: chain clear pulse.
- `shift` out 1: chain load pulse.
- `posX` out 9, `sclX` out 4, `swpX` out 1, `bcolor1`..`bcolor4` out 5 each, `colors` out 32: registered data to chain; valid when `shift`=1, hold their value otherwise.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse, scan finished.
- `overflow` out 1: more than SLOTS hits this line; level until next accepted `line_start`.
- `missed` out 1: one-cycle pulse, `line_start` ignored because busy.

## Operation
- States: IDLE, CLEAR, READ, CHECK, FETCH, PUSH, FIN.
- IDLE: on `line_start`, latch `line`, zero index/hit count, clear `overflow` → CLEAR.
- CLEAR: `clr`=1 for one cycle → READ.
- READ: `attr_rd`=1, `attr_addr`=index → CHECK.
- CHECK: dy = (line − y) mod 256 (8-bit wrap); hit iff dy < 16. A sprite with y=250 therefore hits lines 250..255 and 0..9.
  - hit and count < SLOTS → FETCH, row = dy[3:0].
  - hit and count = SLOTS → set `overflow`, → FIN (scan terminates).
  - no hit: if index = SPRITES−1 → FIN, else index+1 → READ.
- FETCH: `pat_req`=1, `pat_addr` constant. On the `pat_ack` cycle, capture `pat_data` and the attribute fields → PUSH. Pattern data is used as-is; `swpX` is forwarded, not applied.
- PUSH: `shift`=1 for one cycle with captured data on outputs; count+1. If index = SPRITES−1 → FIN, else index+1 → READ.
- FIN: `done`=1 for one cycle → IDLE.
- Lower index = pushed earlier = deeper in the chain. A line loads exactly min(hits, SLOTS) shifts after one `clr`. `clr` and `shift` are never both high.
- `busy`=1 in every state except IDLE.
- `line_start` while busy: ignored, `missed` pulses, scan continues untouched. A `pat_req` is never withdrawn before `pat_ack`.

## Timing
- Reset: state IDLE. All outputs 0: `attr_rd`, `attr_addr`, `pat_req`, `pat_addr`, `clr`, `shift`, `posX`, `sclX`, `swpX`, `bcolor1..4`, `colors`, `busy`, `done`, `overflow`, `missed`. Index and count are 0.
- Reset mid-scan aborts immediately; pending `pat_req` drops. Memories must tolerate this.
- `line_start` at cycle 0 → `clr` at cycle 1 → first `attr_rd` at cycle 2.
- Non-hit sprite: 2 cycles (READ, CHECK).
- Hit sprite: 3 + W cycles, where W ≥ 1 is FETCH cycles including the ack cycle.
- Zero hits: `done` at cycle 2 + 2·SPRITES.
- `pat_ack` is ignored outside FETCH.

## Test plan
- Reset mid-FETCH with `pat_req`=1 → all outputs 0 next edge, `busy`=0; next `line_start` scans normally.
- SPRITES=32, no sprite on line 100 → one `clr` at cycle 1, 32 `attr_rd`, no `shift`, `done` at cycle 66, `overflow`=0.
- Sprites 3 (y=95) and 7 (y=100) on line 100, `pat_ack` 1 cycle after req:
  - fetches go to pat_addr {idx,5} then {idx,0};
  - two `shift` pulses in that order;
  - `colors` equals the acked `pat_data`; `posX`/`bcolor*` match the attributes.
- Wrap: sprite y=250 → hit on line 3 with row 9; no hit on line 10 or line 249.
- All 32 sprites hit line 0, SLOTS=8 → exactly 8 shifts (indices 0–7); `overflow`=1 at sprite 8; `done` follows; `overflow` stays 1 until the next `line_start`.
- `line_start` while busy → `missed` pulse, `line` not re-latched, shift count unchanged. `pat_ack` held low 5 cycles → `pat_req` and `pat_addr` stable throughout.

Source files
------------

// File: rtl/sprite_line_loader.sv
// sprite_line_loader: per-scanline sprite scheduler.
// During hblank it clears the sprite shift-stage chain, walks the attribute
// table, fetches one pattern row for every sprite that intersects the current
// line and shifts attributes plus pattern into the chain, lowest index first.
module sprite_line_loader #(
  parameter int SPRITES = 32,
  parameter int SLOTS   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       line_start,
  input  logic [7:0]                 line,
  output logic                       attr_rd,
  output logic [$clog2(SPRITES)-1:0] attr_addr,
  input  logic [47:0]                attr_data,
  output logic                       pat_req,
  output logic [9:0]                 pat_addr,
  input  logic                       pat_ack,
  input  logic [31:0]                pat_data,
  output logic                       clr,
  output logic                       shift,
  output logic [8:0]                 posX,
  output logic [3:0]                 sclX,
  output logic                       swpX,
  output logic [4:0]                 bcolor1,
  output logic [4:0]                 bcolor2,
  output logic [4:0]                 bcolor3,
  output logic [4:0]                 bcolor4,
  output logic [31:0]                colors,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       missed
);

  localparam int IW = $clog2(SPRITES);
  localparam int CW = $clog2(SLOTS + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, READ, CHECK, FETCH, PUSH, FIN
  } state_t;

  // Attribute fields that travel with the pattern row into the chain.
  typedef struct packed {
    logic [8:0] posx;
    logic [3:0] sclx;
    logic       swpx;
    logic [4:0] bc1;
    logic [4:0] bc2;
    logic [4:0] bc3;
    logic [4:0] bc4;
  } attr_t;

  state_t        state;
  logic [7:0]    line_q;
  logic [IW-1:0] index;
  logic [CW-1:0] count;
  attr_t         attr_q;

  // Attribute word decode, only meaningful in CHECK (memory returns data
  // the cycle after attr_rd).
  logic [7:0] spr_y;
  logic [7:0] dy;
  logic       hit;
  logic       last;
  logic       slot_free;

  assign spr_y     = attr_data[47:40];
  // 8-bit wrap lets sprites straddle line 255 -> 0.
  assign dy        = line_q - spr_y;
  assign hit       = (dy[7:4] == 4'd0);
  assign last      = (index == IW'(SPRITES - 1));
  assign slot_free = (count < CW'(SLOTS));

  // Scan FSM; every output is registered and set on the transition into the
  // state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      line_q    <= '0;
      index     <= '0;
      count     <= '0;
      attr_q    <= '0;
      attr_rd   <= 1'b0;
      attr_addr <= '0;
      pat_req   <= 1'b0;
      pat_addr  <= '0;
      clr       <= 1'b0;
      shift     <= 1'b0;
      posX      <= '0;
      sclX      <= '0;
      swpX      <= 1'b0;
      bcolor1   <= '0;
      bcolor2   <= '0;
      bcolor3   <= '0;
      bcolor4   <= '0;
      colors    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      missed    <= 1'b0;
    end else begin
      // single-cycle strobes default low
      attr_rd <= 1'b0;
      clr     <= 1'b0;
      shift   <= 1'b0;
      done    <= 1'b0;
      // a line_start during a scan is dropped but reported
      missed  <= line_start && (state != IDLE);

      case (state)
        IDLE: begin
          if (line_start) begin
            line_q   <= line;
            index    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            clr      <= 1'b1;
            busy     <= 1'b1;
            state    <= CLEAR;
          end
        end

        CLEAR: begin
          attr_rd   <= 1'b1;
          attr_addr <= index;
          state     <= READ;
        end

        READ: begin
          state <= CHECK;
        end

        CHECK: begin
          if (hit) begin
            if (slot_free) begin
              pat_req  <= 1'b1;
              pat_addr <= {attr_data[5:0], dy[3:0]};
              attr_q   <= attr_data[39:6];
              state    <= FETCH;
            end else begin
              // chain full: stop scanning, flag the line
              overflow <= 1'b1;
              done     <= 1'b1;
              state    <= FIN;
            end
          end else if (last) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            index     <= index + 1'b1;
            attr_rd   <= 1'b1;
            attr_addr <= index + 1'b1;
            state     <= READ;
          end
        end

        FETCH: begin
          // request stays up with a stable address until the ack
          if (pat_ack) begin
            pat_req <= 1'b0;
            shift   <= 1'b1;
            colors  <= pat_data;
            posX    <= attr_q.posx;
            sclX    <= attr_q.sclx;
            swpX    <= attr_q.swpx;
            bcolor1 <= attr_q.bc1;
            bcolor2 <= attr_q.bc2;
            bcolor3 <= attr_q.bc3;
            bcolor4 <= attr_q.bc4;
            count   <= count + 1'b1;
            state   <= PUSH;
          end
        end

        PUSH: begin
          if (last) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            index     <= index + 1'b1;
            attr_rd   <= 1'b1;
            attr_addr <= index + 1'b1;
            state     <= READ;
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          pat_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
